program_loader: RTL and testbench

Synthesizable boot-image loader that owns the memory port while the core is held in reset. It zero-fills the program region, streams a program image into memory from `BASE_ADDR`, optionally reads it back against a checksum, then releases the core with a trigger pulse and runs it for a bounded cycle count. It replaces the manual `mem_write`/`addr_in`/`manual_mem` sequencing with a parametrised block that sits between the image source, the memory mux and the core reset/trigger.

---
 rtl/program_loader_pkg.sv | 68 ++++++
 rtl/program_loader_checksum.sv | 40 ++++
 rtl/program_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_program_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : program_loader_pkg
// Description : Shared types and constants for the boot-image loader:
//               FSM state encoding, error codes, default address map and the
//               state-to-output decode used to register the control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
package program_loader_pkg;

    // Default program region when the integrator does not override it
    localparam int unsigned INSTRUCTION_BASE = 32'h0000_00F0;
    localparam int unsigned MEM_DEPTH        = 256;

    localparam logic [1:0] LDR_ERR_NONE = 2'd0;
    localparam logic [1:0] LDR_ERR_OVF  = 2'd1;
    localparam logic [1:0] LDR_ERR_CSUM = 2'd2;

    typedef enum logic [2:0] {
        LDR_IDLE    = 3'd0,
        LDR_ZERO    = 3'd1,
        LDR_LOAD    = 3'd2,
        LDR_VERIFY  = 3'd3,
        LDR_RELEASE = 3'd4,
        LDR_RUN     = 3'd5,
        LDR_DONE    = 3'd6,
        LDR_ERROR   = 3'd7
    } ldr_state_e;

    typedef struct packed {
        logic mem_sel;
        logic core_reset;
        logic trigger;
        logic busy;
        logic done;
        logic error;
        logic img_ready;
    } ldr_outs_t;

    // Control outputs are a pure function of the state being entered, so
    // registering this decode keeps them glitch-free within a state.
    function automatic ldr_outs_t ldr_decode(input ldr_state_e s);
        ldr_outs_t o;
        o = '{mem_sel: 1'b1, core_reset: 1'b1, default: 1'b0};
        case (s)
            LDR_ZERO:    o.busy = 1'b1;
            LDR_LOAD:    begin o.busy = 1'b1; o.img_ready = 1'b1; end
            LDR_VERIFY:  o.busy = 1'b1;
            LDR_RELEASE: begin
                o.busy       = 1'b1;
                o.mem_sel    = 1'b0;
                o.core_reset = 1'b0;
                o.trigger    = 1'b1;
            end
            LDR_RUN:     begin
                o.busy       = 1'b1;
                o.mem_sel    = 1'b0;
                o.core_reset = 1'b0;
            end
            LDR_DONE:    o.done  = 1'b1;
            LDR_ERROR:   o.error = 1'b1;
            default:     o.busy  = 1'b0;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/program_loader_checksum.sv
`default_nettype none
// ============================================================================
// Module      : ldr_checksum
// Description : Modular-sum accumulator with synchronous clear and enable.
//               Data is zero-extended to CSUM_WIDTH before being added.
//               sum_next_o exposes the value the register takes on this edge.
// Revision    : 1.0 - initial release
// ============================================================================
module ldr_checksum #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CSUM_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CSUM_WIDTH-1:0] sum_o,
    output logic [CSUM_WIDTH-1:0] sum_next_o
);

    logic [CSUM_WIDTH-1:0] sum_q;

    // Running sum including the current data word when enabled
    always_comb begin
        sum_next_o = en_i ? (sum_q + CSUM_WIDTH'(data_i)) : sum_q;
    end

    // Accumulator register; clear wins over enable
    always_ff @(posedge clk) begin
        if (clear_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_next_o;
        end
    end

    assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module      : program_loader
// Description : Boot-image loader. Owns the memory port while the core is in
//               reset: zero-fills the program region, streams the image in,
//               optionally reads it back against a checksum, then pulses
//               trigger and lets the core run for RUN_CYCLES cycles.
//               Optional feature macro: PROGRAM_LOADER_VERIFY_EN (read-back
//               checksum verify stage).
// Revision    : 1.0 - initial release
// ============================================================================
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = INSTRUCTION_BASE,
    parameter int unsigned END_ADDR   = MEM_DEPTH - 1,
    parameter int unsigned CSUM_WIDTH = 16,
    parameter int unsigned RUN_CYCLES = 75
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  img_valid_i,
    input  logic [DATA_WIDTH-1:0] img_data_i,
    input  logic                  img_last_i,
    output logic                  img_ready_o,
    output logic                  mem_sel_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    output logic                  mem_we_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i,
    output logic                  core_reset_o,
    output logic                  trigger_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [1:0]            error_code_o,
    output logic [ADDR_WIDTH-1:0] load_count_o
);

    localparam logic [ADDR_WIDTH-1:0] c_base = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_end  = ADDR_WIDTH'(END_ADDR);
    localparam int unsigned           c_run_w = (RUN_CYCLES < 2) ? 1 : $clog2(RUN_CYCLES);
    localparam logic [c_run_w-1:0]    c_run_last =
        c_run_w'((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1);

    ldr_state_e             state_q, state_d;
    ldr_outs_t              outs_q;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [1:0]             err_q, err_d;
    logic [c_run_w-1:0]     run_q, run_d;

    logic                   w_start;
    logic                   w_beat;
    logic                   w_csum_clr;
    logic [CSUM_WIDTH-1:0]  w_csum;
    logic [CSUM_WIDTH-1:0]  w_csum_next_unused;

    // Start is honoured only when the loader is parked
    assign w_start = start_i && ((state_q == LDR_IDLE) || (state_q == LDR_DONE) ||
                                 (state_q == LDR_ERROR));
    // An accepted image beat; reset drops any beat presented on its edge
    assign w_beat     = (state_q == LDR_LOAD) && img_valid_i && !reset;
    assign w_csum_clr = reset || w_start;

    ldr_checksum #(
        .DATA_WIDTH (DATA_WIDTH),
        .CSUM_WIDTH (CSUM_WIDTH)
    ) u_csum (
        .clk        (clk),
        .clear_i    (w_csum_clr),
        .en_i       (w_beat),
        .data_i     (img_data_i),
        .sum_o      (w_csum),
        .sum_next_o (w_csum_next_unused)
    );

`ifdef PROGRAM_LOADER_VERIFY_EN
    logic [ADDR_WIDTH-1:0]  vcnt_q, vcnt_d;
    logic                   w_rsum_en;
    logic [CSUM_WIDTH-1:0]  w_rsum_unused;
    logic [CSUM_WIDTH-1:0]  w_rsum_next;

    // Read data lags the address by one cycle, so accumulation starts at vcnt 1
    assign w_rsum_en = (state_q == LDR_VERIFY) && (vcnt_q != '0);

    ldr_checksum #(
        .DATA_WIDTH (DATA_WIDTH),
        .CSUM_WIDTH (CSUM_WIDTH)
    ) u_rsum (
        .clk        (clk),
        .clear_i    (reset || (state_q != LDR_VERIFY)),
        .en_i       (w_rsum_en),
        .data_i     (mem_dout_i),
        .sum_o      (w_rsum_unused),
        .sum_next_o (w_rsum_next)
    );
`else
    logic w_unused;
    assign w_unused = ^{mem_dout_i, w_csum};
`endif

    // Next-state and datapath update rules
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        run_d   = run_q;
`ifdef PROGRAM_LOADER_VERIFY_EN
        vcnt_d  = vcnt_q;
`endif
        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERROR: begin
                if (w_start) begin
                    state_d = LDR_ZERO;
                    ptr_d   = c_base;
                    cnt_d   = '0;
                    err_d   = LDR_ERR_NONE;
                end
            end
            LDR_ZERO: begin
                if (ptr_q == c_end) begin
                    ptr_d   = c_base;
                    state_d = LDR_LOAD;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            LDR_LOAD: begin
                if (w_beat) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (img_last_i) begin
`ifdef PROGRAM_LOADER_VERIFY_EN
                        state_d = LDR_VERIFY;
                        vcnt_d  = '0;
`else
                        state_d = LDR_RELEASE;
`endif
                    end else if (ptr_q == c_end) begin
                        state_d = LDR_ERROR;
                        err_d   = LDR_ERR_OVF;
                    end
                end
            end
`ifdef PROGRAM_LOADER_VERIFY_EN
            LDR_VERIFY: begin
                // Last read data is on mem_dout when vcnt equals the beat count
                if (vcnt_q == cnt_q) begin
                    if (w_rsum_next == w_csum) begin
                        state_d = LDR_RELEASE;
                    end else begin
                        state_d = LDR_ERROR;
                        err_d   = LDR_ERR_CSUM;
                    end
                end else begin
                    vcnt_d = vcnt_q + 1'b1;
                end
            end
`endif
            LDR_RELEASE: begin
                state_d = LDR_RUN;
                run_d   = '0;
            end
            LDR_RUN: begin
                // RUN_CYCLES of zero keeps the core running until reset
                if ((RUN_CYCLES != 0) && (run_q == c_run_last)) begin
                    state_d = LDR_DONE;
                end else if (RUN_CYCLES != 0) begin
                    run_d = run_q + 1'b1;
                end
            end
            default: state_d = LDR_IDLE;
        endcase
    end

    // Memory port: writes in ZERO and on accepted beats, reads in VERIFY
    always_comb begin
        mem_we_o   = 1'b0;
        mem_addr_o = ptr_q;
        mem_din_o  = '0;
        case (state_q)
            LDR_ZERO: mem_we_o = !reset;
            LDR_LOAD: begin
                mem_we_o  = w_beat;
                mem_din_o = img_data_i;
            end
`ifdef PROGRAM_LOADER_VERIFY_EN
            LDR_VERIFY: mem_addr_o = c_base + vcnt_q;
`endif
            default: mem_we_o = 1'b0;
        endcase
    end

    // State, datapath and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LDR_IDLE;
            outs_q  <= ldr_decode(LDR_IDLE);
            ptr_q   <= c_base;
            cnt_q   <= '0;
            err_q   <= LDR_ERR_NONE;
            run_q   <= '0;
`ifdef PROGRAM_LOADER_VERIFY_EN
            vcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            outs_q  <= ldr_decode(state_d);
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            run_q   <= run_d;
`ifdef PROGRAM_LOADER_VERIFY_EN
            vcnt_q  <= vcnt_d;
`endif
        end
    end

    assign img_ready_o  = outs_q.img_ready;
    assign mem_sel_o    = outs_q.mem_sel;
    assign core_reset_o = outs_q.core_reset;
    assign trigger_o    = outs_q.trigger;
    assign busy_o       = outs_q.busy;
    assign done_o       = outs_q.done;
    assign error_o      = outs_q.error;
    assign error_code_o = err_q;
    assign load_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_loader
// Description : Self-checking bench for program_loader with a 256-byte
//               memory model, table-driven image vectors, randomized images
//               against a behavioural outcome model, and hand-written
//               reset / corruption sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_loader;

    localparam int AW   = 16;
    localparam int DW   = 8;
    localparam int RUNC = 75;
`ifdef PROGRAM_LOADER_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    logic          clk = 1'b0;
    logic          reset, start, img_valid, img_last;
    logic [DW-1:0] img_data;
    logic          img_ready, mem_sel, mem_we, core_reset, trigger, busy, done, error;
    logic [AW-1:0] mem_addr, load_count;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [1:0]    error_code;

    logic [7:0] mem [0:255] = '{default: 8'h55};
    logic [7:0] img [0:31];
    logic       corrupt_f1 = 1'b0;
    int         cyc = 0;
    int         wr_cnt = 0;
    int         trig_cnt = 0;
    int         tests = 0;
    int         fails = 0;
    int         last_beat_cyc = 0;

    typedef struct {
        int          len;
        bit          has_last;
        int          gap_mode;
        bit          exp_ovf;
        int          exp_cnt;
        logic [23:0] head;
    } vec_t;
    vec_t vecs [7];

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BASE_ADDR  (32'h00F0),
        .END_ADDR   (32'h00FF),
        .CSUM_WIDTH (16),
        .RUN_CYCLES (RUNC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .img_valid_i  (img_valid),
        .img_data_i   (img_data),
        .img_last_i   (img_last),
        .img_ready_o  (img_ready),
        .mem_sel_o    (mem_sel),
        .mem_addr_o   (mem_addr),
        .mem_din_o    (mem_din),
        .mem_we_o     (mem_we),
        .mem_dout_i   (mem_dout),
        .core_reset_o (core_reset),
        .trigger_o    (trigger),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .error_code_o (error_code),
        .load_count_o (load_count)
    );

    // Memory model with 1-cycle read latency, plus write / trigger counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we && mem_sel) begin
            mem[mem_addr[7:0]] <= mem_din;
            wr_cnt <= wr_cnt + 1;
        end
        if (trigger) trig_cnt <= trig_cnt + 1;
        mem_dout <= (corrupt_f1 && mem_addr == 16'h00F1) ? ~mem[mem_addr[7:0]]
                                                        : mem[mem_addr[7:0]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fire start from a parked state and wait until LOAD is reached
    task automatic start_seq(input bit detailed);
        bit ok;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_clears_count", load_count, 0);
        check("start_clears_status", {done, error, error_code}, 0);
        check("busy_in_zero", busy, 1);
        if (detailed) begin
            for (int i = 0; i < 16; i++) begin
                if (i > 0) @(negedge clk);
                check("zero_we", mem_we, 1);
                check("zero_addr", mem_addr, 32'h00F0 + i);
                check("zero_din", mem_din, 0);
            end
            @(negedge clk);
            check("ready_after_zero", img_ready, 1);
        end else begin
            ok = 1'b0;
            for (int c = 0; c < 40; c++) begin
                if (img_ready) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("reach_load", ok, 1);
        end
    endtask

    // gap_mode: 0 back-to-back, 1 every other cycle, 2 random 0..2 idle cycles
    task automatic drive_image(input int len, input bit has_last, input int gap_mode);
        int g;
        for (int i = 0; i < len; i++) begin
            if (!img_ready) break;
            g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            if (i > 0) begin
                for (int k = 0; k < g; k++) begin
                    img_valid = 1'b0;
                    img_last  = 1'b0;
                    @(negedge clk);
                end
            end
            img_valid = 1'b1;
            img_data  = img[i];
            img_last  = has_last && (i == len - 1);
            @(negedge clk);
            last_beat_cyc = cyc;
        end
        img_valid = 1'b0;
        img_last  = 1'b0;
    endtask

    task automatic run_case(input int len, input bit has_last, input int gap_mode,
                            input bit exp_ovf, input int exp_cnt, input bit detailed);
        int wr0, tr0, t_trig, t_done;
        bit got;
        start_seq(detailed);
        wr0 = wr_cnt;
        tr0 = trig_cnt;
        drive_image(len, has_last, gap_mode);
        t_trig = -1;
        t_done = -1;
        got    = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (trigger && t_trig < 0) t_trig = cyc;
            if (done || error) begin
                got    = 1'b1;
                t_done = cyc;
                break;
            end
            @(negedge clk);
        end
        check("finished", got, 1);
        check("error", error, exp_ovf);
        check("done", done, !exp_ovf);
        check("error_code", error_code, exp_ovf ? 1 : 0);
        check("load_count", load_count, exp_cnt);
        check("writes", wr_cnt - wr0, exp_cnt);
        check("trigger_pulses", trig_cnt - tr0, exp_ovf ? 0 : 1);
        if (!exp_ovf) begin
            check("trigger_time", t_trig, last_beat_cyc + VER * (exp_cnt + 1));
            check("done_time", t_done, t_trig + RUNC + 1);
        end
        check("core_reset_end", core_reset, 1);
        check("mem_sel_end", mem_sel, 1);
        check("busy_end", busy, 0);
        for (int i = 0; i < 16; i++) begin
            check("mem", mem[8'hF0 + i], (i < exp_cnt) ? img[i] : 8'h00);
        end
    endtask

    initial begin
        bit ovf;
        int len, cnt;
        bit hl;
        int w0;

        reset     = 1'b1;
        start     = 1'b0;
        img_valid = 1'b0;
        img_last  = 1'b0;
        img_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_mem_sel", mem_sel, 1);
        check("rst_core_reset", core_reset, 1);
        check("rst_others", {img_ready, mem_we, trigger, busy, done, error, error_code}, 0);
        check("rst_load_count", load_count, 0);

        vecs[0] = '{len: 3,  has_last: 1, gap_mode: 0, exp_ovf: 0, exp_cnt: 3,  head: 24'hA90500};
        vecs[1] = '{len: 17, has_last: 0, gap_mode: 0, exp_ovf: 1, exp_cnt: 16, head: 24'h123456};
        vecs[2] = '{len: 3,  has_last: 1, gap_mode: 1, exp_ovf: 0, exp_cnt: 3,  head: 24'hA90500};
        vecs[3] = '{len: 16, has_last: 1, gap_mode: 0, exp_ovf: 0, exp_cnt: 16, head: 24'hFFEE01};
        vecs[4] = '{len: 1,  has_last: 1, gap_mode: 0, exp_ovf: 0, exp_cnt: 1,  head: 24'h7E0000};
        vecs[5] = '{len: 16, has_last: 0, gap_mode: 2, exp_ovf: 1, exp_cnt: 16, head: 24'h0102FF};
        vecs[6] = '{len: 18, has_last: 1, gap_mode: 0, exp_ovf: 1, exp_cnt: 16, head: 24'h808080};

        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < 32; i++) begin
                img[i] = 8'(i * 29 + v * 7 + 1);
            end
            img[0] = vecs[v].head[23:16];
            img[1] = vecs[v].head[15:8];
            img[2] = vecs[v].head[7:0];
            run_case(vecs[v].len, vecs[v].has_last, vecs[v].gap_mode,
                     vecs[v].exp_ovf, vecs[v].exp_cnt, v == 0);
        end

        // Randomized images: outcome follows from where img_last falls
        for (int r = 0; r < 6; r++) begin
            len = int'($urandom_range(1, 20));
            hl  = (len < 16) ? 1'b1 : 1'($urandom % 2);
            for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
            ovf = !(hl && len <= 16);
            cnt = ovf ? 16 : len;
            run_case(len, hl, int'($urandom_range(0, 2)), ovf, cnt, 1'b0);
        end

        // Reset mid-LOAD; start during LOAD is ignored, in-flight beat dropped
        start_seq(1'b0);
        img_valid = 1'b1;
        img_data  = 8'h11;
        @(negedge clk);
        start    = 1'b1;
        img_data = 8'h22;
        @(negedge clk);
        start = 1'b0;
        check("load_ignores_start_ready", img_ready, 1);
        check("load_ignores_start_count", load_count, 2);
        reset    = 1'b1;
        img_data = 8'h33;
        w0       = wr_cnt;
        @(negedge clk);
        reset     = 1'b0;
        img_valid = 1'b0;
        check("midrst_mem_sel", mem_sel, 1);
        check("midrst_core_reset", core_reset, 1);
        check("midrst_load_count", load_count, 0);
        check("midrst_idle", {img_ready, busy}, 0);
        check("midrst_no_write", wr_cnt - w0, 0);
        check("midrst_mem_f2", mem[8'hF2], 8'h00);

`ifdef PROGRAM_LOADER_VERIFY_EN
        // Read-back corruption at 0xF1 must abort with a checksum error
        img[0] = 8'hA9;
        img[1] = 8'h05;
        img[2] = 8'h00;
        start_seq(1'b0);
        corrupt_f1 = 1'b1;
        w0 = trig_cnt;
        drive_image(3, 1'b1, 0);
        for (int c = 0; c < 100; c++) begin
            if (done || error) break;
            @(negedge clk);
        end
        corrupt_f1 = 1'b0;
        check("csum_error", error, 1);
        check("csum_code", error_code, 2);
        check("csum_core_reset", core_reset, 1);
        check("csum_no_trigger", trig_cnt - w0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
